// File: rtl/bht_update_ctrl.sv
// ============================================================================
// Module  : bht_update_ctrl
// Purpose : Checkpoint queue for conditional-branch predictions; emits BHT
//           updates in resolve order and repairs the speculative GHR.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bht_update_ctrl #(
  parameter int unsigned NR_ENTRIES = 8,
  parameter int unsigned GHR_BITS   = 4,
  parameter int unsigned VLEN       = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          debug_mode_i,
  input  logic                          push_valid_i,
  output logic                          push_ready_o,
  input  logic [VLEN-1:0]               push_pc_i,
  input  logic                          push_taken_i,
  input  logic                          resolve_valid_i,
  input  logic [VLEN-1:0]               resolve_pc_i,
  input  logic                          resolve_taken_i,
  input  logic                          resolve_mispredict_i,
  output logic [GHR_BITS-1:0]           ghr_o,
  // Packed as {valid, pc[VLEN-1:0], taken}
  output logic [VLEN+1:0]               bht_update_o,
  output logic [GHR_BITS-1:0]           update_ghr_o,
  output logic                          mismatch_o,
  output logic [$clog2(NR_ENTRIES):0]   occupancy_o
);

  localparam int unsigned PTR_W = $clog2(NR_ENTRIES);
  localparam logic [PTR_W:0] c_ptr_one = {{PTR_W{1'b0}}, 1'b1};

  logic [VLEN-1:0]     r_pc_mem    [NR_ENTRIES];
  logic                r_taken_mem [NR_ENTRIES];
  logic [GHR_BITS-1:0] r_snap_mem  [NR_ENTRIES];

  logic [PTR_W:0]      r_wptr, r_rptr;
  logic [GHR_BITS-1:0] r_ghr;
  logic                r_upd_valid;
  logic [VLEN-1:0]     r_upd_pc;
  logic                r_upd_taken;
  logic [GHR_BITS-1:0] r_upd_ghr;
  logic                r_mismatch;

  logic                w_empty, w_full, w_head_match;
  logic                w_resolve_ok, w_mispredict, w_mismatch, w_pop, w_push, w_clear;
  logic [PTR_W-1:0]    w_widx, w_ridx;
  logic [GHR_BITS-1:0] w_head_snap;

  assign w_widx      = r_wptr[PTR_W-1:0];
  assign w_ridx      = r_rptr[PTR_W-1:0];
  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (w_widx == w_ridx) && (r_wptr[PTR_W] != r_rptr[PTR_W]);
  assign w_head_snap = r_snap_mem[w_ridx];
  assign w_head_match = !w_empty && (r_pc_mem[w_ridx] == resolve_pc_i);

  // Flush dominates everything; a mispredict or mismatch squashes the queue
  // and any same-cycle push since it is on the wrong path.
  assign w_resolve_ok = resolve_valid_i && w_head_match && !flush_i;
  assign w_mispredict = w_resolve_ok && resolve_mispredict_i;
  assign w_mismatch   = resolve_valid_i && !w_head_match && !flush_i;
  assign w_pop        = w_resolve_ok && !resolve_mispredict_i;
  assign w_clear      = flush_i || w_mispredict || w_mismatch;
  assign w_push       = push_valid_i && !w_full && !w_clear;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ghr  <= '0;
    end else if (w_clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
      if (w_mispredict) r_ghr <= {w_head_snap[GHR_BITS-2:0], resolve_taken_i};
      else              r_ghr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_ptr_one;
        r_ghr  <= {r_ghr[GHR_BITS-2:0], push_taken_i};
      end
      if (w_pop) r_rptr <= r_rptr + c_ptr_one;
    end
  end

  // Queue payload needs no reset: entries are only read between the pointers.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_pc_mem[w_widx]    <= push_pc_i;
      r_taken_mem[w_widx] <= push_taken_i;
      r_snap_mem[w_widx]  <= r_ghr;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_upd_valid <= 1'b0;
      r_upd_pc    <= '0;
      r_upd_taken <= 1'b0;
      r_upd_ghr   <= '0;
      r_mismatch  <= 1'b0;
    end else begin
      r_upd_valid <= w_resolve_ok && !debug_mode_i;
      r_mismatch  <= w_mismatch;
      if (w_resolve_ok) begin
        r_upd_pc    <= r_pc_mem[w_ridx];
        r_upd_taken <= resolve_taken_i;
        r_upd_ghr   <= w_head_snap;
      end
    end
  end

  // Stored prediction bit is kept for the entry record but not needed here.
  logic w_unused_taken;
  assign w_unused_taken = r_taken_mem[w_ridx];

  assign push_ready_o = !w_full;
  assign ghr_o        = r_ghr;
  assign bht_update_o = {r_upd_valid, r_upd_pc, r_upd_taken};
  assign update_ghr_o = r_upd_ghr;
  assign mismatch_o   = r_mismatch;
  assign occupancy_o  = r_wptr - r_rptr;

endmodule

`default_nettype wire

// File: tb/tb_bht_update_ctrl.sv
// ============================================================================
// Module  : tb_bht_update_ctrl
// Purpose : Directed and random stimulus for bht_update_ctrl vs. a queue model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bht_update_ctrl;

  localparam int NR = 8;
  localparam int GB = 4;
  localparam int VL = 64;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            flush_i = 1'b0;
  logic            debug_mode_i = 1'b0;
  logic            push_valid_i = 1'b0;
  logic            push_ready_o;
  logic [VL-1:0]   push_pc_i = '0;
  logic            push_taken_i = 1'b0;
  logic            resolve_valid_i = 1'b0;
  logic [VL-1:0]   resolve_pc_i = '0;
  logic            resolve_taken_i = 1'b0;
  logic            resolve_mispredict_i = 1'b0;
  logic [GB-1:0]   ghr_o;
  logic [VL+1:0]   bht_update_o;
  logic [GB-1:0]   update_ghr_o;
  logic            mismatch_o;
  logic [$clog2(NR):0] occupancy_o;

  bht_update_ctrl #(.NR_ENTRIES(NR), .GHR_BITS(GB), .VLEN(VL)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .debug_mode_i(debug_mode_i),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o), .push_pc_i(push_pc_i),
    .push_taken_i(push_taken_i), .resolve_valid_i(resolve_valid_i),
    .resolve_pc_i(resolve_pc_i), .resolve_taken_i(resolve_taken_i),
    .resolve_mispredict_i(resolve_mispredict_i), .ghr_o(ghr_o),
    .bht_update_o(bht_update_o), .update_ghr_o(update_ghr_o),
    .mismatch_o(mismatch_o), .occupancy_o(occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [63:0] pc;
    logic        taken;
    logic [3:0]  snap;
  } ent_t;

  ent_t        m_q[$];
  logic [3:0]  m_ghr;
  logic        m_uv, m_ut, m_mis;
  logic [63:0] m_upc;
  logic [3:0]  m_ughr;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ghr = '0; m_uv = 0; m_ut = 0; m_mis = 0; m_upc = '0; m_ughr = '0;
  endtask

  task automatic check_outputs(input string ph);
    check({ph, ":ghr"},      64'(ghr_o), 64'(m_ghr));
    check({ph, ":occ"},      64'(occupancy_o), 64'(m_q.size()));
    check({ph, ":ready"},    64'(push_ready_o), 64'(m_q.size() < NR));
    check({ph, ":upd_v"},    64'(bht_update_o[VL+1]), 64'(m_uv));
    check({ph, ":mismatch"}, 64'(mismatch_o), 64'(m_mis));
    if (m_uv) begin
      check({ph, ":upd_pc"},  64'(bht_update_o[VL:1]), m_upc);
      check({ph, ":upd_t"},   64'(bht_update_o[0]), 64'(m_ut));
      check({ph, ":upd_ghr"}, 64'(update_ghr_o), 64'(m_ughr));
    end
  endtask

  // One clock: drive after a falling edge, advance the model, check at next falling edge.
  task automatic cycle(input string ph, input bit pv, input logic [63:0] ppc, input bit pt,
                       input bit rv, input logic [63:0] rpc, input bit rt, input bit rmp,
                       input bit fl, input bit dbg);
    bit   ready, matched;
    ent_t head;
    push_valid_i = pv; push_pc_i = ppc; push_taken_i = pt;
    resolve_valid_i = rv; resolve_pc_i = rpc; resolve_taken_i = rt;
    resolve_mispredict_i = rmp; flush_i = fl; debug_mode_i = dbg;

    ready   = (m_q.size() < NR);
    matched = (m_q.size() > 0) && (m_q[0].pc == rpc);
    m_uv = 0; m_mis = 0;
    if (fl) begin
      m_q.delete(); m_ghr = '0;
    end else if (rv && matched) begin
      head = m_q[0];
      m_uv = !dbg; m_upc = head.pc; m_ut = rt; m_ughr = head.snap;
      if (rmp) begin
        m_q.delete();
        m_ghr = {head.snap[2:0], rt};
      end else begin
        void'(m_q.pop_front());
        if (pv && ready) begin
          m_q.push_back('{pc: ppc, taken: pt, snap: m_ghr});
          m_ghr = {m_ghr[2:0], pt};
        end
      end
    end else if (rv) begin
      m_mis = 1; m_q.delete(); m_ghr = '0;
    end else if (pv && ready) begin
      m_q.push_back('{pc: ppc, taken: pt, snap: m_ghr});
      m_ghr = {m_ghr[2:0], pt};
    end

    @(posedge clk_i);
    @(negedge clk_i);
    check_outputs(ph);
  endtask

  task automatic idle(input string ph);
    cycle(ph, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push(input string ph, input logic [63:0] pc, input bit t);
    cycle(ph, 1, pc, t, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [63:0] pc;
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    check_outputs("reset");
    check("reset:upd_vec", 64'(bht_update_o[VL+1:1]), 64'd0);
    check("reset:upd_ghr", 64'(update_ghr_o), 64'd0);

    // Basic push / resolve
    push("p100", 64'h100, 1);
    check("p100:ghr_exp", 64'(ghr_o), 64'b0001);
    push("p104", 64'h104, 0);
    check("p104:ghr_exp", 64'(ghr_o), 64'b0010);
    cycle("r100", 0, 0, 0, 1, 64'h100, 1, 0, 0, 0);
    check("r100:upd_pc_exp", 64'(bht_update_o[VL:1]), 64'h100);
    check("r100:occ_exp", 64'(occupancy_o), 64'd1);

    // Mispredict repair with a dropped same-cycle push
    cycle("flush0", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    push("m0", 64'h300, 1);
    push("m1", 64'h304, 1);
    push("m2", 64'h308, 1);
    cycle("mp", 1, 64'h30c, 1, 1, 64'h300, 0, 1, 0, 0);
    check("mp:ghr_exp", 64'(ghr_o), 64'b0000);
    check("mp:occ_exp", 64'(occupancy_o), 64'd0);
    idle("mp_after");

    // Fill, overflow attempt, then push/resolve pairs across the wrap
    for (int i = 0; i < NR; i++) push("fill", 64'h1000 + 64'(i * 4), i[0]);
    check("full:ready_exp", 64'(push_ready_o), 64'd0);
    push("ovf", 64'h2000, 1);
    check("ovf:occ_exp", 64'(occupancy_o), 64'd8);
    for (int i = 0; i < 20; i++)
      cycle("wrap", 1, 64'h3000 + 64'(i * 4), 1'($urandom_range(0, 1)),
            1, m_q[0].pc, 1'($urandom_range(0, 1)), 0, 0, 0);
    while (m_q.size() > 0) cycle("drain", 0, 0, 0, 1, m_q[0].pc, 1, 0, 0, 0);

    // Mismatch: PC differs, then resolve on an empty queue
    push("mm_p", 64'h100, 1);
    cycle("mm_pc", 0, 0, 0, 1, 64'h200, 1, 0, 0, 0);
    check("mm_pc:mis_exp", 64'(mismatch_o), 64'd1);
    idle("mm_gap");
    check("mm_gap:mis_exp", 64'(mismatch_o), 64'd0);
    cycle("mm_empty", 0, 0, 0, 1, 64'h100, 0, 0, 0, 0);

    // Debug mode suppresses only the update pulse; flush beats push and resolve
    push("dbg_p", 64'h400, 0);
    cycle("dbg_r", 0, 0, 0, 1, 64'h400, 0, 0, 0, 1);
    check("dbg_r:occ_exp", 64'(occupancy_o), 64'd0);
    push("fl_p0", 64'h500, 1);
    push("fl_p1", 64'h504, 1);
    cycle("fl_all", 1, 64'h508, 1, 1, 64'h500, 1, 0, 1, 0);
    idle("fl_after");

    // Asynchronous reset in mid-cycle with state and a live update pulse
    push("ar_p0", 64'h600, 1);
    push("ar_p1", 64'h604, 1);
    cycle("ar_r", 0, 0, 0, 1, 64'h600, 1, 0, 0, 0);
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle("ar_release");

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      bit use_head;
      pc = {$urandom, $urandom} & ~64'h3;
      use_head = (m_q.size() > 0) && ($urandom_range(0, 9) < 8);
      cycle("rand",
            $urandom_range(0, 9) < 6, pc, 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) < 4,
            use_head ? m_q[0].pc : ({$urandom, $urandom} & ~64'h3),
            1'($urandom_range(0, 1)),
            $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 20);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
